// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, LSB-first data, optional even parity, stop bit(s).
// Every output comes from a flop, so the line and the status flags only move on a clock edge
// or on reset.
module serial_frame_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D,
  input  logic             Load,
  output logic             Ready,
  output logic             Q,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cyc_q, cyc_d;
  logic [4:0]        bit_q, bit_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              q_q, q_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;

  // State and output registers; reset forces the line idle immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      cyc_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      q_q      <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      q_q      <= q_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; q_d is the line value for the cycle after the coming edge.
  always_comb begin
    state_d  = state_q;
    cyc_d    = '0;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    q_d      = q_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bit_end  = (cyc_q == CntW'(CLKS_PER_BIT - 1));

    if (state_q != StIdle) begin
      cyc_d = bit_end ? '0 : cyc_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (Load && ready_q) begin
          shift_d  = D;
          parity_d = ^D;
          state_d  = StStart;
          q_d      = 1'b0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          bit_d    = '0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          q_d     = shift_q[0];
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == 5'(WIDTH - 1)) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = StParity;
              q_d     = parity_q;
            end else begin
              state_d = StStop;
              q_d     = 1'b1;
            end
          end else begin
            bit_d = bit_q + 5'd1;
            q_d   = shift_d[0];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          q_d     = 1'b1;
          bit_d   = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_q == 5'(STOP_BITS - 1)) begin
            state_d = StIdle;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            q_d     = 1'b1;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign Ready = ready_q;
  assign Q     = q_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule
